text_line_ctrl: RTL and testbench
=================================

TEXT_LINE_CTRL -- requirements
Module: text_line_ctrl

Interface
REQ-001 Parameter: BLINK_FRAMES, default 30, frames per cursor-blink half-period (legal range 1..63).
REQ-002 Parameter: BLANK_CODE, default 6'd63, glyph code written to erased slots.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 ch_valid  in  1  character-write request.
REQ-006 ch_code  in  6  glyph code: 0-9 digits, 10-35 letters A-Z, 63 blank; 36-62 invalid.
REQ-007 ch_ready  out  1  high when a command is accepted this cycle.
REQ-008 bksp  in  1  backspace request.
REQ-009 clr  in  1  clear-line request.
REQ-010 frame_start  in  1  one-cycle pulse per VGA frame, already in clk domain.
REQ-011 text_buffer_in_line  out  60  displayed line; slot i at bits [6i+5:6i], slot 0 leftmost.
REQ-012 cursor_pos  out  4  displayed cursor slot, 0..10.
REQ-013 cursor_on  out  1  blink phase for cursor rendering.
REQ-014 line_full  out  1  high when the working cursor equals 10.
REQ-015 overflow  out  1  one-cycle pulse when a write or backspace is rejected.

Function
REQ-016 The block SHALL hold a 10-slot working line, a working cursor wcur, a dirty flag, and a separate display copy driving text_buffer_in_line and cursor_pos.
REQ-017 FSM states SHALL be IDLE and CLEAR; ch_ready = 1 only in IDLE.
REQ-018 In IDLE, command priority SHALL be clr > bksp > ch_valid; lower-priority requests in the same cycle are dropped, not queued.
REQ-019 Write: if wcur < 10 and ch_code is valid, slot[wcur] <= ch_code, wcur <= wcur+1, dirty <= 1, all on the accepting edge.
REQ-020 Write with wcur = 10 SHALL leave the line unchanged and pulse overflow on the next cycle; a write with an invalid code SHALL be ignored silently.
REQ-021 Backspace: if wcur > 0, wcur <= wcur-1, slot[wcur-1] <= BLANK_CODE, dirty <= 1; if wcur = 0, no change and overflow pulses.
REQ-022 Clear: IDLE -> CLEAR; in CLEAR, one slot per cycle from 0 to 9 SHALL be set to BLANK_CODE (10 cycles); on the slot-9 cycle wcur <= 0, dirty <= 1, and the state returns to IDLE.
REQ-023 Display update: on frame_start in IDLE with dirty = 1, the display copy <= the working line and wcur, and dirty <= 0, visible the next cycle.
REQ-024 frame_start coincident with an accepted command SHALL copy the pre-command working state; dirty SHALL remain 1.
REQ-025 frame_start during CLEAR SHALL NOT copy; dirty is kept so the next frame_start after CLEAR publishes the blank line.
REQ-026 The blink counter SHALL count frame_start pulses 0..BLINK_FRAMES-1, wrap to 0, and toggle cursor_on on each wrap.
REQ-027 line_full SHALL be combinational from wcur (== 10); cursor_pos reflects only the display copy.

Reset
REQ-028 On rst high, asynchronously: state IDLE, all working and display slots BLANK_CODE (text_buffer_in_line = 60'hFFF_FFFF_FFFF_FFFF), wcur = 0, cursor_pos = 0, dirty = 0, blink counter = 0, cursor_on = 1, overflow = 0, line_full = 0.
REQ-029 rst asserted mid-CLEAR SHALL abort the clear and return to the full reset state; the first command after deassertion is accepted in the first IDLE cycle.

Verification
REQ-030 Write codes 1,2,3 in three cycles, then pulse frame_start -> next cycle text_buffer_in_line[17:0] = {6'd3,6'd2,6'd1}, upper slots 63, cursor_pos = 3.
REQ-031 Eleven valid writes -> line_full = 1 after the 10th; the 11th leaves the line unchanged and overflow pulses once.
REQ-032 clr, bksp and ch_valid asserted together in IDLE -> CLEAR entered, ch_ready = 0 for 10 cycles, then the working line is all 63 with wcur = 0.
REQ-033 frame_start in the same cycle as write code 5 at wcur = 0 -> display unchanged; the next frame_start shows slot0 = 5, cursor_pos = 1.
REQ-034 BLINK_FRAMES = 30: 30 frame_start pulses -> cursor_on toggles 1->0 after the 30th, back to 1 after the 60th.
REQ-035 rst pulsed during CLEAR cycle 4 -> all outputs at REQ-028 values; the next write lands in slot 0.

Source files
------------

// File: rtl/text_line_ctrl.sv
// Ten-slot text line editor with frame-synchronous display copy and cursor blink.
// Commands take effect on the accepting edge; ch_ready drops for the 10-cycle clear sweep, and requests during it are dropped.
module text_line_ctrl #(
    parameter int          BLINK_FRAMES = 30,
    parameter logic [5:0]  BLANK_CODE   = 6'd63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch_valid,
    input  logic [5:0]  ch_code,
    output logic        ch_ready,
    input  logic        bksp,
    input  logic        clr,
    input  logic        frame_start,
    output logic [59:0] text_buffer_in_line,
    output logic [3:0]  cursor_pos,
    output logic        cursor_on,
    output logic        line_full,
    output logic        overflow
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [59:0] BLANK_LINE = {10{BLANK_CODE}};
    localparam logic [5:0]  BLINK_LAST = 6'(BLINK_FRAMES - 1);

    state_t           state_q, state_d;
    logic [9:0][5:0]  line_q, line_d;
    logic [3:0]       wcur_q, wcur_d;
    logic             dirty_q, dirty_d;
    logic [59:0]      disp_q, disp_d;
    logic [3:0]       dcur_q, dcur_d;
    logic [3:0]       clr_idx_q, clr_idx_d;
    logic [5:0]       blink_cnt_q, blink_cnt_d;
    logic             cursor_on_q, cursor_on_d;
    logic             overflow_q, overflow_d;

    logic code_ok;
    logic cmd;
    logic copy;

    assign code_ok = (ch_code <= 6'd35) || (ch_code == 6'd63);
    assign cmd     = clr | bksp | ch_valid;
    assign copy    = frame_start && (state_q == IDLE) && dirty_q;

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        wcur_d      = wcur_q;
        dirty_d     = dirty_q;
        disp_d      = disp_q;
        dcur_d      = dcur_q;
        clr_idx_d   = clr_idx_q;
        blink_cnt_d = blink_cnt_q;
        cursor_on_d = cursor_on_q;
        overflow_d  = 1'b0;

        if (frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 6'd0;
                cursor_on_d = ~cursor_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 6'd1;
            end
        end

        // Snapshot uses pre-command state; a coincident command keeps the line dirty.
        if (copy) begin
            disp_d  = line_q;
            dcur_d  = wcur_q;
            dirty_d = cmd;
        end

        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d   = CLEAR;
                    clr_idx_d = 4'd0;
                end else if (bksp) begin
                    if (wcur_q != 4'd0) begin
                        wcur_d                  = wcur_q - 4'd1;
                        line_d[wcur_q - 4'd1]   = BLANK_CODE;
                        dirty_d                 = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (ch_valid) begin
                    if (wcur_q == 4'd10) begin
                        overflow_d = 1'b1;
                    end else if (code_ok) begin
                        line_d[wcur_q] = ch_code;
                        wcur_d         = wcur_q + 4'd1;
                        dirty_d        = 1'b1;
                    end
                end
            end
            CLEAR: begin
                line_d[clr_idx_q] = BLANK_CODE;
                if (clr_idx_q == 4'd9) begin
                    wcur_d  = 4'd0;
                    dirty_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            line_q      <= BLANK_LINE;
            wcur_q      <= 4'd0;
            dirty_q     <= 1'b0;
            disp_q      <= BLANK_LINE;
            dcur_q      <= 4'd0;
            clr_idx_q   <= 4'd0;
            blink_cnt_q <= 6'd0;
            cursor_on_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            wcur_q      <= wcur_d;
            dirty_q     <= dirty_d;
            disp_q      <= disp_d;
            dcur_q      <= dcur_d;
            clr_idx_q   <= clr_idx_d;
            blink_cnt_q <= blink_cnt_d;
            cursor_on_q <= cursor_on_d;
            overflow_q  <= overflow_d;
        end
    end

    assign ch_ready            = (state_q == IDLE);
    assign text_buffer_in_line = disp_q;
    assign cursor_pos          = dcur_q;
    assign cursor_on           = cursor_on_q;
    assign line_full           = (wcur_q == 4'd10);
    assign overflow            = overflow_q;

endmodule

// File: tb/tb_text_line_ctrl.sv
// Bench for text_line_ctrl: behavioural line model feeding an expected-output queue, plus directed checks.
module tb_text_line_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ch_valid;
    logic [5:0]  ch_code;
    logic        ch_ready;
    logic        bksp;
    logic        clr;
    logic        frame_start;
    logic [59:0] text_buffer_in_line;
    logic [3:0]  cursor_pos;
    logic        cursor_on;
    logic        line_full;
    logic        overflow;

    text_line_ctrl #(.BLINK_FRAMES(30), .BLANK_CODE(6'd63)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ch_valid            (ch_valid),
        .ch_code             (ch_code),
        .ch_ready            (ch_ready),
        .bksp                (bksp),
        .clr                 (clr),
        .frame_start         (frame_start),
        .text_buffer_in_line (text_buffer_in_line),
        .cursor_pos          (cursor_pos),
        .cursor_on           (cursor_on),
        .line_full           (line_full),
        .overflow            (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [59:0] txt;
        logic [3:0]  cur;
        logic [3:0]  misc;   // {cursor_on, line_full, overflow, ch_ready}
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    logic [5:0] m_line [10];
    int         m_wcur, m_idx, m_cnt;
    logic       m_dirty, m_clear, m_on, m_ovf;
    logic [59:0] m_disp;
    logic [3:0]  m_dcur;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [59:0] pack_line();
        logic [59:0] t;
        for (int i = 0; i < 10; i++) t[6*i +: 6] = m_line[i];
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_line[i] = 6'd63;
        m_wcur = 0; m_idx = 0; m_cnt = 0;
        m_dirty = 1'b0; m_clear = 1'b0; m_on = 1'b1; m_ovf = 1'b0;
        m_disp = {60{1'b1}}; m_dcur = 4'd0;
    endtask

    task automatic model_step(input logic v, input logic [5:0] code, input logic b,
                              input logic c, input logic fs);
        logic cmd;
        cmd   = c | b | v;
        m_ovf = 1'b0;
        if (fs) begin
            if (m_cnt == 29) begin m_cnt = 0; m_on = ~m_on; end
            else m_cnt++;
        end
        if (!m_clear) begin
            if (fs && m_dirty) begin
                m_disp  = pack_line();
                m_dcur  = 4'(m_wcur);
                m_dirty = cmd;
            end
            if (c) begin
                m_clear = 1'b1;
                m_idx   = 0;
            end else if (b) begin
                if (m_wcur > 0) begin
                    m_wcur--;
                    m_line[m_wcur] = 6'd63;
                    m_dirty = 1'b1;
                end else m_ovf = 1'b1;
            end else if (v) begin
                if (m_wcur == 10) m_ovf = 1'b1;
                else if (code <= 6'd35 || code == 6'd63) begin
                    m_line[m_wcur] = code;
                    m_wcur++;
                    m_dirty = 1'b1;
                end
            end
        end else begin
            m_line[m_idx] = 6'd63;
            if (m_idx == 9) begin
                m_clear = 1'b0; m_wcur = 0; m_dirty = 1'b1;
            end else m_idx++;
        end
    endtask

    // One clock: drive, predict into the queue, then compare after the edge.
    task automatic step(input logic v, input logic [5:0] code, input logic b,
                        input logic c, input logic fs);
        exp_t e;
        exp_t got;
        ch_valid = v; ch_code = code; bksp = b; clr = c; frame_start = fs;
        model_step(v, code, b, c, fs);
        e.txt  = m_disp;
        e.cur  = m_dcur;
        e.misc = {m_on, (m_wcur == 10), m_ovf, ~m_clear};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        ch_valid = 1'b0; bksp = 1'b0; clr = 1'b0; frame_start = 1'b0;
        got.txt  = text_buffer_in_line;
        got.cur  = cursor_pos;
        got.misc = {cursor_on, line_full, overflow, ch_ready};
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("sb_txt", {4'd0, got.txt}, {4'd0, e.txt});
            check("sb_cur", {60'd0, got.cur}, {60'd0, e.cur});
            check("sb_misc", {60'd0, got.misc}, {60'd0, e.misc});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [5:0] code);
        step(1'b1, code, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fs_pulse();
        step(1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txt"}, {4'd0, text_buffer_in_line}, {4'd0, 60'hFFF_FFFF_FFFF_FFFF});
        check({tag, "_cur"}, {60'd0, cursor_pos}, 64'd0);
        check({tag, "_misc"}, {60'd0, cursor_on, line_full, overflow, ch_ready}, 64'h9);
    endtask

    initial begin
        int nzero;
        int novf;
        rst = 1'b1; ch_valid = 1'b0; ch_code = 6'd0; bksp = 1'b0; clr = 1'b0; frame_start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Blink: cursor_on falls after the 30th frame pulse and rises after the 60th.
        for (int i = 0; i < 29; i++) fs_pulse();
        check("blink29", {63'd0, cursor_on}, 64'd1);
        fs_pulse();
        check("blink30", {63'd0, cursor_on}, 64'd0);
        for (int i = 0; i < 30; i++) fs_pulse();
        check("blink60", {63'd0, cursor_on}, 64'd1);

        // Frame coincident with first write: display unchanged, next frame shows it.
        step(1'b1, 6'd5, 1'b0, 1'b0, 1'b1);
        check("coinc_txt", {4'd0, text_buffer_in_line}, {4'd0, 60'hFFF_FFFF_FFFF_FFFF});
        check("coinc_cur", {60'd0, cursor_pos}, 64'd0);
        fs_pulse();
        check("coinc_slot0", {58'd0, text_buffer_in_line[5:0]}, 64'd5);
        check("coinc_cur1", {60'd0, cursor_pos}, 64'd1);

        // All three requests together: clear wins and holds off ready for 10 cycles.
        nzero = 0;
        step(1'b1, 6'd7, 1'b1, 1'b1, 1'b0);
        if (!ch_ready) nzero++;
        for (int i = 0; i < 9; i++) begin
            idle(1);
            if (!ch_ready) nzero++;
        end
        check("clr_busy", nzero, 64'd10);
        idle(1);
        check("clr_ready", {63'd0, ch_ready}, 64'd1);
        fs_pulse();
        check("clr_blank", {4'd0, text_buffer_in_line}, {4'd0, 60'hFFF_FFFF_FFFF_FFFF});
        check("clr_cur", {60'd0, cursor_pos}, 64'd0);

        // Three writes then a frame.
        wr(6'd1); wr(6'd2); wr(6'd3);
        fs_pulse();
        check("w123_lo", {46'd0, text_buffer_in_line[17:0]}, {46'd0, 6'd3, 6'd2, 6'd1});
        check("w123_hi", {22'd0, text_buffer_in_line[59:18]}, {22'd0, {42{1'b1}}});
        check("w123_cur", {60'd0, cursor_pos}, 64'd3);

        // Fill to ten, then one more write is rejected with a single overflow pulse.
        for (int i = 0; i < 7; i++) wr(6'(10 + i));
        check("full10", {63'd0, line_full}, 64'd1);
        novf = 0;
        wr(6'd20);
        if (overflow) novf++;
        idle(2);
        if (overflow) novf++;
        check("ovf_once", novf, 64'd1);
        fs_pulse();
        check("full_slot9", {58'd0, text_buffer_in_line[59:54]}, 64'd16);
        check("full_cur", {60'd0, cursor_pos}, 64'd10);

        // Backspace to empty, then one more is rejected.
        for (int i = 0; i < 10; i++) step(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        check("bksp_ovf", {63'd0, overflow}, 64'd1);

        // Constrained-random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, 6'($urandom_range(0, 63)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 4) == 0);
        end
        idle(12);

        // Reset during the fourth clear cycle aborts everything.
        step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        idle(3);
        #3 rst = 1'b1;
        #1;
        check_reset_outputs("rst_clear");
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("rst_ready", {63'd0, ch_ready}, 64'd1);
        wr(6'd7);
        fs_pulse();
        check("rst_slot0", {58'd0, text_buffer_in_line[5:0]}, 64'd7);
        check("rst_cur", {60'd0, cursor_pos}, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
